// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: PC owner issuing one-word icache fetches into a DEPTH-entry instruction queue
module if_prefetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc0_0000,
    parameter logic [WIDTH-1:0] EXC_PC = 32'hbfc0_0380
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exc_valid,
    input  logic                     eret_valid,
    input  logic [WIDTH-1:0]         epc,
    input  logic                     jump_valid,
    input  logic [WIDTH-1:0]         jump_target,
    input  logic                     branch_valid,
    input  logic [WIDTH-1:0]         branch_target,
    output logic                     icache_req,
    output logic [WIDTH-1:0]         icache_addr,
    input  logic                     icache_ready,
    input  logic                     icache_rvalid,
    input  logic [WIDTH-1:0]         icache_rdata,
    output logic                     inst_valid,
    output logic [WIDTH-1:0]         inst_pc,
    output logic [WIDTH-1:0]         inst_data,
    output logic                     inst_adel,
    input  logic                     inst_ready,
    output logic [WIDTH-1:0]         fetch_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] q_pc [DEPTH];
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [DEPTH-1:0] q_adel;
    logic [AW-1:0] head, tail;
    logic [WIDTH-1:0] req_pc, target;
    logic busy, drop, redirect, misaligned, pop, resp, push_resp, push_adel, push, accept;
    logic [AW+1:0] occ;
    assign redirect = exc_valid || eret_valid || jump_valid || branch_valid;
    assign target = exc_valid ? EXC_PC : eret_valid ? epc : jump_valid ? jump_target : branch_target;
    assign misaligned = fetch_pc[1:0] != 2'b00;
    assign inst_valid = count != '0;
    assign pop = inst_valid && inst_ready;
    // a response only counts while a request is outstanding; stray rvalid after reset is ignored
    assign resp = busy && icache_rvalid;
    assign push_resp = resp && !drop && !redirect;
    // occupancy after this cycle including the outstanding request, used to avoid overflow
    assign occ = {1'b0, count} + (AW+2)'(busy) + (AW+2)'(push_resp) - (AW+2)'(pop);
    assign push_adel = misaligned && !redirect && !busy && occ < (AW+2)'(DEPTH);
    assign push = push_resp || push_adel;
    assign icache_req = !rst && !redirect && !misaligned && (!busy || icache_rvalid) && occ < (AW+2)'(DEPTH);
    assign accept = icache_req && icache_ready;
    assign icache_addr = {3'b000, fetch_pc[WIDTH-4:0]};
    assign inst_pc = q_pc[head];
    assign inst_adel = q_adel[head];
    assign inst_data = q_adel[head] ? '0 : q_data[head];
    // PC, outstanding-request tracking and queue pointers; redirect flushes and marks in-flight data stale
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc <= '0;
            busy <= 1'b0;
            drop <= 1'b0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            busy <= busy && !icache_rvalid;
            drop <= busy && !icache_rvalid;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + WIDTH'(4);
                req_pc <= fetch_pc;
            end
            busy <= accept || (busy && !icache_rvalid);
            if (resp) drop <= 1'b0;
            if (pop) head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // queue storage; a misaligned PC enqueues an address-error entry instead of fetching
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[tail] <= push_adel ? fetch_pc : req_pc;
            q_data[tail] <= push_adel ? '0 : icache_rdata;
            q_adel[tail] <= push_adel;
        end
    end
endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction-fetch front end. It owns the PC, issues one-word fetches to the instruction cache, and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode pulls from the queue under a valid/ready handshake. Redirects (exception, ERET, jump, branch) flush the queue and discard any in-flight response, so fetch no longer stalls the whole pipeline on every cache miss.

## Interface
- WIDTH, 32: address/instruction width
- DEPTH, 4: queue entries; power of two, >= 2
- RESET_PC, 32'hbfc0_0000: PC after reset
- EXC_PC, 32'hbfc0_0380: exception vector

- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- exc_valid  in  1  exception redirect to EXC_PC
- eret_valid  in  1  redirect to epc
- epc  in  WIDTH  ERET target
- jump_valid  in  1  jump redirect
- jump_target  in  WIDTH  jump target (immediate or register, resolved upstream)
- branch_valid  in  1  taken-branch redirect
- branch_target  in  WIDTH  branch target
- icache_req  out  1  fetch request valid
- icache_addr  out  WIDTH  fetch address, {3'b000, fetch_pc[28:0]}
- icache_ready  in  1  cache accepts request this cycle
- icache_rvalid  in  1  response valid (exactly one per accepted request, in order)
- icache_rdata  in  WIDTH  instruction word
- inst_valid  out  1  queue head valid
- inst_pc  out  WIDTH  head PC
- inst_data  out  WIDTH  head instruction (0 when inst_adel)
- inst_adel  out  1  head PC misaligned (fetch address error)
- inst_ready  in  1  decode consumes head
- fetch_pc  out  WIDTH  next PC to fetch
- count  out  log2(DEPTH)+1  valid entries in queue

## Operation
- State: fetch_pc, busy (one request outstanding), req_pc, drop (discard next response), circular queue (head, tail, count), each entry holding {pc, data, adel}.
- Redirect target priority: exc_valid > eret_valid > jump_valid > branch_valid. Any redirect at an edge sets fetch_pc to the target, sets count/head/tail to 0, and sets drop = busy && !icache_rvalid. A response arriving in the redirect cycle is discarded.
- icache_req = !rst && !redirect && fetch_pc[1:0]==0 && (!busy || icache_rvalid) && (count + busy - pop + push) < DEPTH. At most one request is outstanding.
- Accept (icache_req && icache_ready): busy<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^WIDTH).
- Response: if drop, clear drop and busy with no push. Otherwise push {req_pc, icache_rdata, 0} and clear busy unless a new request is accepted in the same cycle.
- Misaligned fetch_pc with no redirect, not busy, and space available: push {fetch_pc, 0, 1} with no cache request. fetch_pc holds until a redirect.
- Pop = inst_valid && inst_ready. Push and pop in the same cycle are allowed; count is unchanged. A redirect overrides pop and push.
- Head outputs read combinationally from the queue; inst_valid = (count != 0).

## Timing
- Reset (edge with rst=1): fetch_pc=RESET_PC, busy=0, drop=0, count=0, inst_valid=0, icache_req=0. First request is at cycle 1 after reset deasserts.
- Minimum latency from accept to inst_valid: 1 cycle after icache_rvalid.
- Zero-wait cache (rvalid the cycle after accept): sustained 1 instruction per cycle once the queue is not full.
- Queue full (count==DEPTH, or count==DEPTH-1 with busy): icache_req low. The queue never overflows.
- Empty with inst_ready=1: no pop, count stays 0.
- Redirect in the same cycle as accept: impossible, because req is gated by redirect.
- Reset mid-request: state cleared. A late rvalid after reset with busy=0 is ignored.

## Test plan
- Reset release, zero-wait cache, inst_ready=1 -> icache_addr 0x1fc00000, 0x1fc00004, ...; inst_pc 0xbfc00000 first, one per cycle.
- inst_ready=0 with DEPTH=4 -> exactly 4 pushes, icache_req low, count=4. Raise ready -> in-order drain, fetching resumes.
- Branch to 0xbfc00100 while busy with a 3-cycle cache -> stale response dropped. Next inst_pc=0xbfc00100 and count was 0 after the redirect.
- exc_valid and jump_valid together -> fetch_pc=0xbfc00380.
- jump_target 0xbfc00102 -> no cache request; inst_valid with inst_adel=1, inst_pc=0xbfc00102, inst_data=0.
- Push and pop in the same cycle at count=2 -> count stays 2, data order preserved.
